// File: rtl/cpu_pkg.sv
// Shared datapath constants: extension mode encodings, default extender widths
// and the handshake state encoding used by imm_extend_pipe.
package cpu_pkg;

    localparam int EXT_MODE_W = 3;
    localparam int IMM_IN_W   = 16;
    localparam int IMM_OUT_W  = 32;

    localparam logic [EXT_MODE_W-1:0] EXT_ZERO      = 3'd0;
    localparam logic [EXT_MODE_W-1:0] EXT_SIGN      = 3'd1;
    localparam logic [EXT_MODE_W-1:0] EXT_UPPER     = 3'd2;
    localparam logic [EXT_MODE_W-1:0] EXT_SIGN_SHL2 = 3'd3;
    localparam logic [EXT_MODE_W-1:0] EXT_BYTE_Z    = 3'd4;
    localparam logic [EXT_MODE_W-1:0] EXT_BYTE_S    = 3'd5;
    localparam logic [EXT_MODE_W-1:0] EXT_HALF_Z    = 3'd6;
    localparam logic [EXT_MODE_W-1:0] EXT_HALF_S    = 3'd7;

    // ST_ONE is "output register full"; ST_TWO additionally means the skid entry is full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ext_state_t;

endpackage

// File: rtl/imm_extend_core.sv
// Purely combinational extension mux: widens in_data to OUT_W according to in_mode.
module imm_extend_core
    import cpu_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W
) (
    input  logic [IN_W-1:0]       in_data,
    input  logic [EXT_MODE_W-1:0] in_mode,
    output logic [OUT_W-1:0]      ext_data
);

    logic [OUT_W-1:0] sign_ext;

    assign sign_ext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

    always_comb begin
        ext_data = '0;
        case (in_mode)
            EXT_ZERO:      ext_data = {{(OUT_W-IN_W){1'b0}}, in_data};
            EXT_SIGN:      ext_data = sign_ext;
            EXT_UPPER:     ext_data = {in_data, {(OUT_W-IN_W){1'b0}}};
            EXT_SIGN_SHL2: ext_data = {sign_ext[OUT_W-3:0], 2'b00};
            EXT_BYTE_Z:    ext_data = {{(OUT_W-8){1'b0}}, in_data[7:0]};
            EXT_BYTE_S:    ext_data = {{(OUT_W-8){in_data[7]}}, in_data[7:0]};
            EXT_HALF_Z:    ext_data = {{(OUT_W-16){1'b0}}, in_data[15:0]};
            EXT_HALF_S:    ext_data = {{(OUT_W-16){in_data[15]}}, in_data[15:0]};
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate/data extender with valid/ready handshakes and a sideband tag.
// Define IMM_EXTEND_SKID_EN to add a 1-entry skid register so in_ready is registered.
module imm_extend_pipe
    import cpu_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    input  logic [EXT_MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_neg
);

    logic [OUT_W-1:0] ext_data;
    ext_state_t       state;
    ext_state_t       state_next;
    logic             accept;
    logic             load_out;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_data  (in_data),
        .in_mode  (in_mode),
        .ext_data (ext_data)
    );

    assign out_valid = (state != ST_EMPTY);
    assign out_neg   = out_data[OUT_W-1];

`ifdef IMM_EXTEND_SKID_EN

    logic [OUT_W-1:0] skid_data;
    logic [TAG_W-1:0] skid_tag;
    logic             load_skid;
    logic             pop_skid;

    // in_ready decodes only the state register, so out_ready never reaches it combinationally.
    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        pop_skid   = 1'b0;
        in_ready   = (state != ST_TWO);
        accept     = in_valid && in_ready;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_out   = 1'b1;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (out_ready) begin
                    if (accept) load_out = 1'b1;
                    else        state_next = ST_EMPTY;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = ST_TWO;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    pop_skid   = 1'b1;
                    state_next = ST_ONE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            out_data  <= '0;
            out_tag   <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            state <= state_next;
            if (pop_skid) begin
                out_data <= skid_data;
                out_tag  <= skid_tag;
            end else if (load_out) begin
                out_data <= ext_data;
                out_tag  <= in_tag;
            end
            if (load_skid) begin
                skid_data <= ext_data;
                skid_tag  <= in_tag;
            end
        end
    end

`else

    // A full output register can still accept when the consumer drains it in the same cycle.
    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        in_ready   = (state == ST_EMPTY) || out_ready;
        accept     = in_valid && in_ready;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_out   = 1'b1;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept)         load_out = 1'b1;
                else if (out_ready) state_next = ST_EMPTY;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            state <= state_next;
            if (load_out) begin
                out_data <= ext_data;
                out_tag  <= in_tag;
            end
        end
    end

`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed mode vectors, reset, throughput,
// backpressure, random handshakes against a scoreboard, and a 20->40 bit variant.
module tb_imm_extend_pipe;
    import cpu_pkg::*;

`ifdef IMM_EXTEND_SKID_EN
    localparam int EXP_BP_ACCEPTS = 2;
`else
    localparam int EXP_BP_ACCEPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_neg;

    logic        d2_in_valid;
    logic        d2_in_ready;
    logic [19:0] d2_in_data;
    logic [2:0]  d2_in_mode;
    logic [4:0]  d2_in_tag;
    logic        d2_out_valid;
    logic        d2_out_ready;
    logic [39:0] d2_out_data;
    logic [4:0]  d2_out_tag;
    logic        d2_out_neg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_data_q[$];
    logic [4:0]  exp_tag_q[$];
    bit          pending;
    int          sent;
    int          popped;
    int          accepts;
    int          item_limit;
    logic [4:0]  next_tag;

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_neg   (out_neg)
    );

    imm_extend_pipe #(.IN_W(20), .OUT_W(40), .TAG_W(5)) dut_wide (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .in_data   (d2_in_data),
        .in_mode   (d2_in_mode),
        .in_tag    (d2_in_tag),
        .out_valid (d2_out_valid),
        .out_ready (d2_out_ready),
        .out_data  (d2_out_data),
        .out_tag   (d2_out_tag),
        .out_neg   (d2_out_neg)
    );

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference extension model, written arithmetically rather than as bit concatenations.
    function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [2:0] m);
        logic [7:0] b;
        b = d[7:0];
        case (m)
            3'd0:    return 32'(d);
            3'd1:    return 32'($signed(d));
            3'd2:    return 32'(d) * 32'h0001_0000;
            3'd3:    return 32'($signed(d)) * 32'd4;
            3'd4:    return 32'(b);
            3'd5:    return 32'($signed(b));
            3'd6:    return 32'(d);
            default: return 32'($signed(d));
        endcase
    endfunction

    task automatic apply_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        d2_in_valid = 1'b0;
        out_ready   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pending = 1'b0;
        sent    = 0;
        popped  = 0;
        accepts = 0;
        next_tag = '0;
        exp_data_q.delete();
        exp_tag_q.delete();
    endtask

    // One clock of the scoreboard-driven stream; entered and left at posedge+1.
    task automatic apply_stimulus(input bit try_valid, input bit rdy);
        bit acc;
        out_ready = rdy;
        if (!pending && try_valid && sent < item_limit) begin
            in_data  = 16'($urandom);
            in_mode  = 3'($urandom_range(0, 7));
            in_tag   = next_tag;
            next_tag = next_tag + 5'd1;
            in_valid = 1'b1;
            pending  = 1'b1;
        end else if (!pending) begin
            in_valid = 1'b0;
        end
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
                check_output("sb_underflow", 64'd1, 64'd0);
            end else begin
                logic [31:0] ed;
                logic [4:0]  et;
                ed = exp_data_q.pop_front();
                et = exp_tag_q.pop_front();
                check_output("sb_data", 64'(out_data), 64'(ed));
                check_output("sb_tag", 64'(out_tag), 64'(et));
                check_output("sb_neg", 64'(out_neg), 64'(ed[31]));
            end
            popped++;
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_data_q.push_back(ref_ext(in_data, in_mode));
            exp_tag_q.push_back(in_tag);
            pending = 1'b0;
            sent++;
            accepts++;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && (pending || exp_data_q.size() > 0); c++) begin
            apply_stimulus(1'b0, 1'b1);
        end
        check_output("drain_done", 64'(exp_data_q.size()), 64'd0);
        check_output("drain_pending", 64'(pending), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] sw_data [8];
        logic [31:0] sw_exp  [8];
        logic [31:0] held;
        sw_data = '{16'h8F34, 16'h8F34, 16'h8F34, 16'h8F34, 16'h8F34, 16'h0080, 16'h8F34, 16'h8F34};
        sw_exp  = '{32'h00008F34, 32'hFFFF8F34, 32'h8F340000, 32'hFFFE3CD0,
                    32'h00000034, 32'hFFFFFF80, 32'h00008F34, 32'hFFFF8F34};
        in_data = '0; in_mode = '0; in_tag = '0;
        d2_in_data = '0; d2_in_mode = '0; d2_in_tag = '0; d2_out_ready = 1'b1;
        item_limit = 0;

        apply_reset();
        check_output("rst_valid", 64'(out_valid), 64'd0);
        check_output("rst_data", 64'(out_data), 64'd0);
        check_output("rst_tag", 64'(out_tag), 64'd0);
        check_output("rst_neg", 64'(out_neg), 64'd0);
        check_output("rst_ready", 64'(in_ready), 64'd1);

        // Mode sweep: each result must be visible exactly one cycle after the accept.
        out_ready = 1'b1;
        for (int m = 0; m < 8; m++) begin
            in_valid = 1'b1;
            in_data  = sw_data[m];
            in_mode  = 3'(m);
            in_tag   = 5'(m + 3);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_output($sformatf("mode%0d_valid", m), 64'(out_valid), 64'd1);
            check_output($sformatf("mode%0d_data", m), 64'(out_data), 64'(sw_exp[m]));
            check_output($sformatf("mode%0d_tag", m), 64'(out_tag), 64'(m + 3));
            check_output($sformatf("mode%0d_neg", m), 64'(out_neg), 64'(sw_exp[m][31]));
            @(posedge clk);
            #1;
            check_output($sformatf("mode%0d_drop", m), 64'(out_valid), 64'd0);
        end

        // Wide variant.
        d2_in_valid = 1'b1;
        d2_in_data  = 20'h80001;
        d2_in_mode  = EXT_SIGN;
        d2_in_tag   = 5'd17;
        @(posedge clk);
        #1;
        check_output("wide_sign_valid", 64'(d2_out_valid), 64'd1);
        check_output("wide_sign_data", 64'(d2_out_data), 64'h00_FFFFF80001);
        check_output("wide_sign_neg", 64'(d2_out_neg), 64'd1);
        d2_in_mode = EXT_UPPER;
        @(posedge clk);
        #1;
        d2_in_valid = 1'b0;
        check_output("wide_upper_data", 64'(d2_out_data), 64'h00_8000100000);
        check_output("wide_upper_tag", 64'(d2_out_tag), 64'd17);

        // Reset in the middle of a held transfer.
        in_valid = 1'b1; in_data = 16'h8F34; in_mode = EXT_SIGN; in_tag = 5'd9; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_output("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check_output("midrst_valid", 64'(out_valid), 64'd0);
        check_output("midrst_data", 64'(out_data), 64'd0);
        check_output("midrst_tag", 64'(out_tag), 64'd0);
        check_output("midrst_neg", 64'(out_neg), 64'd0);
        apply_reset();
        check_output("post_rst_ready", 64'(in_ready), 64'd1);

        // Back-to-back: eight accepts with no output bubbles.
        item_limit = 8;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b1);
            check_output($sformatf("b2b%0d_valid", i), 64'(out_valid), 64'd1);
            check_output($sformatf("b2b%0d_tag", i), 64'(out_tag), 64'(i));
        end
        drain();
        check_output("b2b_count", 64'(popped), 64'd8);

        // Backpressure: consumer stalled for four cycles.
        apply_reset();
        item_limit = 10;
        apply_stimulus(1'b1, 1'b0);
        held = out_data;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
        check_output("bp_accepts", 64'(accepts), 64'(EXP_BP_ACCEPTS));
        check_output("bp_in_ready", 64'(in_ready), 64'd0);
        check_output("bp_stable", 64'(out_data), 64'(held));
        check_output("bp_valid", 64'(out_valid), 64'd1);
        drain();
        check_output("bp_drained", 64'(popped), 64'(accepts));

        // Random valid/ready toggling.
        apply_reset();
        item_limit = 1000;
        for (int c = 0; c < 8000 && sent < item_limit; c++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        check_output("rand_sent", 64'(sent), 64'd1000);
        check_output("rand_popped", 64'(popped), 64'd1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, registered immediate/data extender for the multicycle datapath.
- Supports zero, sign, upper, branch-offset, byte-load and half-load extension modes.
- Carries a sideband tag and uses valid/ready handshakes on both sides.
- Sits between the IR/MDR and the ALU-B / register-writeback muxes, replacing fixed 16→32 zero extension.

Parameters:
- IN_W, 16: input immediate/data width; must be ≥16.
- OUT_W, 32: output width; must be >IN_W.
- TAG_W, 5: sideband tag width (e.g. destination register number); must be ≥1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in_data  input  IN_W  immediate or loaded data
- in_mode  input  3  extension mode, encoding below
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_data  output  OUT_W  extended result
- out_tag  output  TAG_W  tag of the result
- out_neg  output  1  MSB of out_data

Behaviour:
- Mode encoding:
  - 0 ZERO: upper bits zero.
  - 1 SIGN: replicate in_data[IN_W-1].
  - 2 UPPER: in_data << (OUT_W-IN_W), low bits zero.
  - 3 SIGN_SHL2: SIGN result << 2, top 2 bits dropped (mod 2^OUT_W).
  - 4 BYTE_Z: zero-extend in_data[7:0].
  - 5 BYTE_S: sign-extend in_data[7:0].
  - 6 HALF_Z: zero-extend in_data[15:0].
  - 7 HALF_S: sign-extend in_data[15:0].
- Extension is computed combinationally from the inputs and captured on accept (in_valid && in_ready).
- Latency: exactly 1 cycle from accept to out_valid with the skid buffer disabled; see Optional Feature.
- Handshake rules:
  - Transfer occurs on valid&&ready.
  - in_valid/in_data/in_mode/in_tag must stay stable while in_valid && !in_ready.
  - out_data/out_tag stay stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
- Single-register state machine (skid buffer disabled): EMPTY/FULL.
  - EMPTY + accept → FULL.
  - FULL + out_ready + accept → FULL (new data, back-to-back, full throughput).
  - FULL + out_ready, no accept → EMPTY.
  - FULL + !out_ready → FULL (hold).
- in_ready = !out_valid || out_ready.
- Reset (any time, including mid-transfer):
  - out_valid=0, out_data=0, out_tag=0, out_neg=0.
  - Skid state cleared; in-flight data discarded.
  - in_ready=1 while reset is deasserted and the block is empty.
- Tag is never modified; out_neg is derived from registered out_data.

Optional Feature:
- Macro: IMM_EXTEND_SKID_EN.
- Defined: adds a 1-entry skid register.
  - in_ready is registered: in_ready = !skid_valid. No combinational path from out_ready to in_ready.
  - States: EMPTY, ONE (output reg full), TWO (output + skid full).
  - TWO pops skid into the output on out_ready.
  - Latency is still 1 cycle when empty; throughput remains 1/cycle.
  - When out_ready is low, the block absorbs up to 2 items before in_ready falls.
- Undefined: single-register behaviour above; in_ready combinationally depends on out_ready.

Decomposition:
- Shared package (cpu_pkg), constants:
  - EXT_ZERO … EXT_HALF_S, EXT_MODE_W=3.
  - Default widths IN_W/OUT_W.
- One sub-module: imm_extend_core, the purely combinational mode mux (in_data, in_mode → extended value).
- The top level holds the handshake/skid registers.

Test Plan:
- Reset: assert reset mid-stream with out_valid=1 → next sample shows out_valid=0, out_data=0, out_tag=0; after release in_ready=1.
- Mode sweep, IN_W=16/OUT_W=32, in_data=16'h8F34, out_ready=1:
  - ZERO → 32'h00008F34
  - SIGN → 32'hFFFF8F34
  - UPPER → 32'h8F340000
  - SIGN_SHL2 → 32'hFFFE3CD0
  - BYTE_Z → 32'h00000034
  - BYTE_S with data 16'h0080 → 32'hFFFFFF80
  - HALF_Z → 32'h00008F34
  - HALF_S → 32'hFFFF8F34
  - Each result appears 1 cycle after accept, with out_neg matching bit 31.
- Back-to-back: in_valid held high for 8 cycles with incrementing tag, out_ready=1 → 8 consecutive out_valid cycles, tags 0..7 in order, no bubbles.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1.
  - Without the macro: exactly 1 item accepted, in_ready=0 afterwards.
  - With IMM_EXTEND_SKID_EN: exactly 2 items accepted.
  - Either way, out_data is stable throughout and items drain in order once out_ready=1.
- Random valid/ready toggling, 1000 items, scoreboard against a reference model → no loss, duplication or reordering; data/tag match.
- Parameter variant IN_W=20, OUT_W=40: SIGN of 20'h80001 → 40'hFFFFF80001; UPPER → 40'h8000100000.
